// File: rtl/soc_simple_switch_poller_if.sv
// ---------------------------------------------------------------------------
// soc_simple_switch_poller_if
//   Avalon-MM read-only bus between the switch poller (master) and the
//   switch PIO (slave).
//
//   avm_address      master -> slave  word address (poller always drives 0)
//   avm_read         master -> slave  read command
//   avm_waitrequest  slave  -> master stall
//   avm_readdata     slave  -> master read data
//
// Handshake: the master raises avm_read and holds it, with a stable address,
// until a cycle in which avm_waitrequest is low. That cycle is the accept
// cycle. The slave then presents avm_readdata so that it is valid during the
// cycle that lies a fixed number of cycles (the read latency) after the accept
// cycle. The master captures it at the clock edge ending that cycle. Reads are
// never pipelined: at most one read is outstanding.
// ---------------------------------------------------------------------------
interface soc_simple_switch_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/soc_simple_switch_poller.sv
// ---------------------------------------------------------------------------
// soc_simple_switch_poller
//   Avalon-MM read master that polls the switch PIO data register on a fixed
//   period and debounces the sampled switch vector. Fabric logic sees a
//   stable switch state and a one-cycle change pulse, so it can react to the
//   switches without any CPU involvement.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       1 = polling enabled
//   avm          Avalon-MM master port (see soc_simple_switch_poller_if)
//   sw_state     debounced switch state
//   sw_valid     1 once the first stable state has been accepted
//   sw_changed   one-cycle pulse when sw_state changes after sw_valid
//   dbg_state_o  current poll FSM state (IDLE=0, REQ=1, WAIT=2)
// ---------------------------------------------------------------------------
module soc_simple_switch_poller #(
  parameter int WIDTH        = 10,
  parameter int POLL_CYCLES  = 50000,
  parameter int STABLE_COUNT = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  soc_simple_switch_poller_if.master      avm,
  output logic [WIDTH-1:0]                sw_state,
  output logic                            sw_valid,
  output logic                            sw_changed,
  output logic [1:0]                      dbg_state_o
);

  localparam int TMR_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int CNT_W = $clog2(STABLE_COUNT + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [LAT_W-1:0]   lat_q;
  logic               read_q;
  logic [WIDTH-1:0]   cand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sw_state_q;
  logic               sw_valid_q;
  logic               sw_changed_q;

  // Debounce next-state, only committed at the sample edge.
  logic [WIDTH-1:0]   sample;
  logic [CNT_W-1:0]   cnt_d;
  logic               take_d;

  assign sample = avm.avm_readdata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^avm.avm_readdata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    cnt_d  = cnt_q;
    take_d = 1'b0;
    if (sample != cand_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_FULL) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // The new candidate is always the sample itself, so compare against it.
    take_d = (cnt_d == CNT_FULL) && (!sw_valid_q || (sample != sw_state_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      lat_q        <= '0;
      read_q       <= 1'b0;
      cand_q       <= '0;
      cnt_q        <= '0;
      sw_state_q   <= '0;
      sw_valid_q   <= 1'b0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_changed_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!enable) begin
            timer_q <= '0;
          end else if (timer_q == TMR_LAST) begin
            timer_q <= '0;
            read_q  <= 1'b1;
            state_q <= ST_REQ;
          end else begin
            timer_q <= timer_q + TMR_ONE;
          end
        end
        ST_REQ: begin
          if (!avm.avm_waitrequest) begin
            read_q  <= 1'b0;
            lat_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_q == LAT_LAST) begin
            cand_q <= sample;
            cnt_q  <= cnt_d;
            if (take_d) begin
              sw_state_q   <= sample;
              sw_valid_q   <= 1'b1;
              sw_changed_q <= sw_valid_q;
            end
            // The completion cycle is the first cycle of the next poll
            // period, so the timer resumes at 1 rather than 0.
            timer_q <= enable ? TMR_ONE : '0;
            state_q <= ST_IDLE;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign avm.avm_address = 2'd0;
  assign avm.avm_read    = read_q;
  assign sw_state        = sw_state_q;
  assign sw_valid        = sw_valid_q;
  assign sw_changed      = sw_changed_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_soc_simple_switch_poller.sv
// ---------------------------------------------------------------------------
// tb_soc_simple_switch_poller
//   Bench for soc_simple_switch_poller with POLL_CYCLES=8, STABLE_COUNT=3,
//   READ_LATENCY=1. The slave is a registered PIO whose read data is only
//   meaningful in the cycle after acceptance (junk otherwise). A negedge
//   monitor holds a reference model: poll start times derived from enable
//   and completion cycles, and a debounce model based on the history of the
//   last STABLE_COUNT samples.
// ---------------------------------------------------------------------------
module tb_soc_simple_switch_poller;
  localparam int W = 10;
  localparam int P = 8;
  localparam int S = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic enable;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  soc_simple_switch_poller_if bus ();
  logic [W-1:0] sw_state;
  logic         sw_valid;
  logic         sw_changed;
  logic [1:0]   dbg_state;

  soc_simple_switch_poller #(
    .WIDTH(W), .POLL_CYCLES(P), .STABLE_COUNT(S), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .avm(bus),
    .sw_state(sw_state), .sw_valid(sw_valid), .sw_changed(sw_changed),
    .dbg_state_o(dbg_state)
  );

  // ---------------- slave model ----------------
  logic [W-1:0] sw_in;
  always @(posedge clk) begin
    logic [31:0] junk;
    junk = $urandom;
    if (bus.avm_read && !bus.avm_waitrequest)
      bus.avm_readdata <= {junk[31:W], sw_in};
    else
      bus.avm_readdata <= junk;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];     // accepted read data awaiting the sample edge
  logic [W-1:0] hist[$];      // last S samples
  logic [W-1:0] m_state;
  logic         m_valid;
  int  exp_start  = -1;       // cycle the next read must start, -1 = none
  bit  busy       = 0;        // a read is in flight
  bit  in_req     = 0;
  bit  pending    = 0;
  int  sample_cyc = 0;
  int  req_len    = 0;
  int  last_req_len = 0;
  int  last_start = 0;
  int  n_reads    = 0;
  int  n_samples  = 0;
  int  n_pulses   = 0;

  always @(negedge clk) begin
    logic pulse_exp;
    logic [W-1:0] d;
    logic stable;
    pulse_exp = 1'b0;
    if (reset) begin
      exp_q.delete(); hist.delete();
      m_state = '0; m_valid = 1'b0;
      exp_start = -1; busy = 0; in_req = 0; pending = 0;
      chk_eq("rst_read", bus.avm_read, 0);
      chk_eq("rst_state", sw_state, 0);
      chk_eq("rst_valid", sw_valid, 0);
      chk_eq("rst_changed", sw_changed, 0);
    end else begin
      if (pending) begin
        pending = 0; busy = 0; n_samples++;
        if (exp_q.size() == 0) begin
          chk_eq("scoreboard_empty", 0, 1);
        end else begin
          d = exp_q.pop_front();
          hist.push_back(d);
          if (hist.size() > S) void'(hist.pop_front());
          stable = (hist.size() == S);
          foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
          if (stable && (!m_valid || hist[0] != m_state)) begin
            pulse_exp = m_valid;
            m_state = hist[0];
            m_valid = 1'b1;
          end
        end
      end
      if (bus.avm_read) begin
        chk_eq("address", bus.avm_address, 0);
        if (!in_req) begin
          if (busy) chk_eq("overlap_read", 1, 0);
          chk_eq("start_cyc", cyc, exp_start);
          in_req = 1; busy = 1; req_len = 0; n_reads++; last_start = cyc;
        end
        req_len++;
        if (!bus.avm_waitrequest) begin
          exp_q.push_back(sw_in);
          sample_cyc = cyc + 1;
          in_req = 0;
          last_req_len = req_len;
        end
      end else begin
        if (in_req) chk_eq("read_dropped", 0, 1);
        if (!busy && exp_start == cyc) chk_eq("read_at_start", bus.avm_read, 1);
      end
      if (busy && !in_req && cyc == sample_cyc) begin
        pending = 1;
        exp_start = enable ? cyc + P : -1;
      end else if (!busy) begin
        if (!enable) exp_start = -1;
        else if (exp_start == -1) exp_start = cyc + P;
      end
      chk_eq("sw_state", sw_state, m_state);
      chk_eq("sw_valid", sw_valid, m_valid);
      chk_eq("sw_changed", sw_changed, pulse_exp);
      if (sw_changed) n_pulses++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_samples(input int n);
    int target;
    int k;
    target = n_samples + n;
    k = 0;
    while (n_samples < target && k < 60 * n) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (n_samples < target) chk_eq("sample_timeout", n_samples, target);
  endtask

  task automatic wait_read_start();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.avm_read && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.avm_read) chk_eq("read_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nr;
    int np;
    int en_cyc;
    int stall;
    reset = 1'b1;
    enable = 1'b0;
    sw_in = 10'h155;
    bus.avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_read", bus.avm_read, 0);
    chk_eq("reset_valid", sw_valid, 0);
    reset = 1'b0;

    // T1: first acquire after three samples, no change pulse
    @(posedge clk); #1;
    enable = 1'b1;
    wait_samples(2);
    chk_eq("t1_not_yet_valid", sw_valid, 0);
    wait_samples(1);
    chk_eq("t1_valid", sw_valid, 1);
    chk_eq("t1_state", sw_state, 10'h155);
    chk_eq("t1_no_pulse", n_pulses, 0);

    // T2: stable change
    sw_in = 10'h0AA;
    wait_samples(2);
    chk_eq("t2_hold", sw_state, 10'h155);
    wait_samples(1);
    chk_eq("t2_state", sw_state, 10'h0AA);
    chk_eq("t2_one_pulse", n_pulses, 1);

    // T3: back to 155, then bounce
    sw_in = 10'h155;
    wait_samples(3);
    chk_eq("t3_state", sw_state, 10'h155);
    np = n_pulses;
    for (int i = 0; i < 5; i++) begin
      sw_in = (i % 2 == 0) ? 10'h0AA : 10'h155;
      wait_samples(1);
    end
    chk_eq("t3_bounce_state", sw_state, 10'h155);
    chk_eq("t3_bounce_no_pulse", n_pulses, np);

    // T4: five-cycle stall
    nr = n_reads;
    sw_in = 10'h2C3;
    bus.avm_waitrequest = 1'b1;
    wait_read_start();
    repeat (5) @(posedge clk);
    #1 bus.avm_waitrequest = 1'b0;
    wait_samples(1);
    chk_eq("t4_read_len", last_req_len, 6);
    chk_eq("t4_one_read", n_reads - nr, 1);

    // T5: enable drops during REQ
    bus.avm_waitrequest = 1'b1;
    wait_read_start();
    @(posedge clk); #1;
    enable = 1'b0;
    bus.avm_waitrequest = 1'b0;
    np = n_samples;
    wait_samples(1);
    chk_eq("t5_completed", n_samples - np, 1);
    nr = n_reads;
    repeat (30) @(posedge clk);
    #1;
    chk_eq("t5_no_reads", n_reads, nr);
    enable = 1'b1;
    en_cyc = cyc;
    wait_samples(1);
    chk_eq("t5_reenable_start", last_start, en_cyc + P);

    // Randomized polls with random stalls and sticky switch values
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) sw_in = W'($urandom_range(0, 1023));
      stall = $urandom_range(0, 3);
      if (stall > 0) begin
        bus.avm_waitrequest = 1'b1;
        wait_read_start();
        repeat (stall) @(posedge clk);
        #1 bus.avm_waitrequest = 1'b0;
        wait_samples(1);
        chk_eq("rnd_read_len", last_req_len, stall + 1);
      end else begin
        wait_samples(1);
      end
    end

    // T6: async reset during REQ, then full reacquire
    wait_read_start();
    #2 reset = 1'b1;
    #1;
    chk_eq("t6_async_read", bus.avm_read, 0);
    chk_eq("t6_async_valid", sw_valid, 0);
    chk_eq("t6_async_state", sw_state, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_samples(2);
    chk_eq("t6_not_yet_valid", sw_valid, 0);
    wait_samples(1);
    chk_eq("t6_valid", sw_valid, 1);
    chk_eq("t6_state", sw_state, sw_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
